// File: rtl/dic_clock_datapath.sv
// BCD MM:SS time and alarm datapath for the digital clock: digit loads, seconds counting, alarm match.
// Optional macro DIC_ALARM_LATCH_EN makes alarm_trig sticky until alarm_ena drops, ld_alarm rises or reset.
module dic_clock_datapath #(
  parameter int MAX_MTENS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dicRun,
  input  logic       ld_time,
  input  logic       ld_alarm,
  input  logic       dicLdMtens,
  input  logic       dicLdMones,
  input  logic       dicLdStens,
  input  logic       dicLdSones,
  input  logic       valid_num,
  input  logic [3:0] digit,
  input  logic       oneSecStrobe,
  input  logic       alarm_ena,
  output logic [3:0] dicMtens,
  output logic [3:0] dicMones,
  output logic [3:0] dicStens,
  output logic [3:0] dicSones,
  output logic [3:0] alarmMtens,
  output logic [3:0] alarmMones,
  output logic [3:0] alarmStens,
  output logic [3:0] alarmSones,
  output logic       alarm_trig
);

  localparam logic [3:0] MTENS_LIM = 4'(MAX_MTENS);

  // Out-of-range digits are dropped so the register keeps its current value.
  function automatic logic [3:0] load_digit(input logic sel, input logic [3:0] cur,
                                            input logic [3:0] val, input logic [3:0] lim);
    logic [3:0] res;
    if (sel && (val <= lim)) res = val;
    else                     res = cur;
    return res;
  endfunction

  logic [3:0] t_mt_r, t_mo_r, t_st_r, t_so_r;
  logic [3:0] a_mt_r, a_mo_r, a_st_r, a_so_r;
  logic [3:0] t_mt_s, t_mo_s, t_st_s, t_so_s;
  logic [3:0] a_mt_s, a_mo_s, a_st_s, a_so_s;
  logic       load_time_s, load_alarm_s, count_s, match_s, match_r;

  assign load_time_s  = valid_num & ld_time & ~ld_alarm;
  assign load_alarm_s = valid_num & ld_alarm & ~ld_time;
  assign count_s      = dicRun & oneSecStrobe & ~ld_time;
  assign match_s      = ({t_mt_r, t_mo_r, t_st_r, t_so_r} == {a_mt_r, a_mo_r, a_st_r, a_so_r})
                        & alarm_ena & ~ld_time & ~ld_alarm;

  // Time bank next state: load, or one-second increment with the full carry chain in one cycle.
  always_comb begin
    t_mt_s = t_mt_r;
    t_mo_s = t_mo_r;
    t_st_s = t_st_r;
    t_so_s = t_so_r;
    if (load_time_s) begin
      t_mt_s = load_digit(dicLdMtens, t_mt_r, digit, MTENS_LIM);
      t_mo_s = load_digit(dicLdMones, t_mo_r, digit, 4'd9);
      t_st_s = load_digit(dicLdStens, t_st_r, digit, 4'd5);
      t_so_s = load_digit(dicLdSones, t_so_r, digit, 4'd9);
    end else if (count_s) begin
      if (t_so_r >= 4'd9) begin
        t_so_s = 4'd0;
        if (t_st_r >= 4'd5) begin
          t_st_s = 4'd0;
          if (t_mo_r >= 4'd9) begin
            t_mo_s = 4'd0;
            if (t_mt_r >= MTENS_LIM) t_mt_s = 4'd0;
            else                     t_mt_s = t_mt_r + 4'd1;
          end else begin
            t_mo_s = t_mo_r + 4'd1;
          end
        end else begin
          t_st_s = t_st_r + 4'd1;
        end
      end else begin
        t_so_s = t_so_r + 4'd1;
      end
    end else begin
      t_so_s = t_so_r;
    end
  end

  // Alarm bank next state: loads only.
  always_comb begin
    a_mt_s = a_mt_r;
    a_mo_s = a_mo_r;
    a_st_s = a_st_r;
    a_so_s = a_so_r;
    if (load_alarm_s) begin
      a_mt_s = load_digit(dicLdMtens, a_mt_r, digit, MTENS_LIM);
      a_mo_s = load_digit(dicLdMones, a_mo_r, digit, 4'd9);
      a_st_s = load_digit(dicLdStens, a_st_r, digit, 4'd5);
      a_so_s = load_digit(dicLdSones, a_so_r, digit, 4'd9);
    end else begin
      a_so_s = a_so_r;
    end
  end

  // Digit and match registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      {t_mt_r, t_mo_r, t_st_r, t_so_r} <= 16'h0000;
      {a_mt_r, a_mo_r, a_st_r, a_so_r} <= 16'h0000;
      match_r <= 1'b0;
    end else begin
      {t_mt_r, t_mo_r, t_st_r, t_so_r} <= {t_mt_s, t_mo_s, t_st_s, t_so_s};
      {a_mt_r, a_mo_r, a_st_r, a_so_r} <= {a_mt_s, a_mo_s, a_st_s, a_so_s};
      match_r <= match_s;
    end
  end

`ifdef DIC_ALARM_LATCH_EN
  logic latch_r;

  // Sticky trigger: clear has priority over set.
  always_ff @(posedge clk) begin
    if (!rst)                      latch_r <= 1'b0;
    else if (!alarm_ena || ld_alarm) latch_r <= 1'b0;
    else if (match_r)              latch_r <= 1'b1;
    else                           latch_r <= latch_r;
  end

  assign alarm_trig = match_r | latch_r;
`else
  assign alarm_trig = match_r;
`endif

  assign dicMtens   = t_mt_r;
  assign dicMones   = t_mo_r;
  assign dicStens   = t_st_r;
  assign dicSones   = t_so_r;
  assign alarmMtens = a_mt_r;
  assign alarmMones = a_mo_r;
  assign alarmStens = a_st_r;
  assign alarmSones = a_so_r;

endmodule
